// File: rtl/axi4_lite_csr_master_if.sv
// AXI4-Lite bus bundle (32-bit data) shared by the CSR initiator and its slaves.
interface axi4_lite_if #(
   parameter int ADDR_W = 32
);
   logic [ADDR_W-1:0] awaddr;
   logic [2:0]        awprot;
   logic              awvalid;
   logic              awready;
   logic [31:0]       wdata;
   logic [3:0]        wstrb;
   logic              wvalid;
   logic              wready;
   logic [1:0]        bresp;
   logic              bvalid;
   logic              bready;
   logic [ADDR_W-1:0] araddr;
   logic [2:0]        arprot;
   logic              arvalid;
   logic              arready;
   logic [31:0]       rdata;
   logic [1:0]        rresp;
   logic              rvalid;
   logic              rready;

   modport master (
      output awaddr, awprot, awvalid, input awready,
      output wdata, wstrb, wvalid, input wready,
      input bresp, bvalid, output bready,
      output araddr, arprot, arvalid, input arready,
      input rdata, rresp, rvalid, output rready
   );

   modport slave (
      input awaddr, awprot, awvalid, output awready,
      input wdata, wstrb, wvalid, output wready,
      output bresp, bvalid, input bready,
      input araddr, arprot, arvalid, output arready,
      output rdata, rresp, rvalid, input rready
   );
endinterface

// File: rtl/axi4_lite_csr_master.sv
// Single-outstanding AXI4-Lite initiator: command/response stream in, AXI4-Lite out,
// with a B/R timeout and draining of responses that arrive after the timeout.
module axi4_lite_csr_master #(
   parameter int ADDR_W         = 32,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              cmd_valid_i,
   output logic              cmd_ready_o,
   input  logic              cmd_wr_i,
   input  logic [ADDR_W-1:0] cmd_addr_i,
   input  logic [31:0]       cmd_wdata_i,
   input  logic [3:0]        cmd_wstrb_i,
   output logic              resp_valid_o,
   input  logic              resp_ready_i,
   output logic [31:0]       resp_rdata_o,
   output logic [1:0]        resp_code_o,
   output logic              resp_timeout_o,
   axi4_lite_if.master       csr_o,
   output logic [2:0]        dbg_state_o
);

   // Every channel here (cmd, resp, AW, W, B, AR, R) transfers exactly on a cycle where
   // valid && ready; a raised valid is never withdrawn and its payload never changes
   // until that transfer happens.

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_WR    = 3'd1,
      S_WR_B  = 3'd2,
      S_RD_AR = 3'd3,
      S_RD_R  = 3'd4,
      S_RESP  = 3'd5
   } state_t;

   localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
   localparam int CNT_W      = TIMEOUT_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;

   state_t            state_q, state_d;
   logic              aw_done_q, w_done_q;
   logic              aw_done_d, w_done_d;
   logic [ADDR_W-1:0] awaddr_q, araddr_q;
   logic [31:0]       wdata_q;
   logic [3:0]        wstrb_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              orphan_b_q, orphan_r_q;
   logic [31:0]       rdata_q;
   logic [1:0]        code_q;
   logic              timeout_q;

   logic cmd_hs, aw_hs, w_hs, b_hs, ar_hs, r_hs;
   logic timeout_hit;

   assign cmd_hs = cmd_valid_i && cmd_ready_o;
   assign aw_hs  = csr_o.awvalid && csr_o.awready;
   assign w_hs   = csr_o.wvalid && csr_o.wready;
   assign b_hs   = csr_o.bvalid && csr_o.bready;
   assign ar_hs  = csr_o.arvalid && csr_o.arready;
   assign r_hs   = csr_o.rvalid && csr_o.rready;

   assign aw_done_d   = aw_done_q || aw_hs;
   assign w_done_d    = w_done_q || w_hs;
   assign timeout_hit = TIMEOUT_EN && (cnt_q == CNT_LIMIT);

   // State register
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   // Next-state logic; a B/R handshake takes priority over an expiring timeout.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (cmd_hs) state_d = cmd_wr_i ? S_WR : S_RD_AR;
         S_WR:    if (aw_done_d && w_done_d) state_d = S_WR_B;
         S_WR_B:  if (b_hs || timeout_hit) state_d = S_RESP;
         S_RD_AR: if (ar_hs) state_d = S_RD_R;
         S_RD_R:  if (r_hs || timeout_hit) state_d = S_RESP;
         S_RESP:  if (resp_ready_i) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      cmd_ready_o   = rst_n_i && (state_q == S_IDLE) && !orphan_b_q && !orphan_r_q;
      resp_valid_o  = (state_q == S_RESP);
      csr_o.awvalid = (state_q == S_WR) && !aw_done_q;
      csr_o.wvalid  = (state_q == S_WR) && !w_done_q;
      csr_o.bready  = (state_q == S_WR_B) || orphan_b_q;
      csr_o.arvalid = (state_q == S_RD_AR);
      csr_o.rready  = (state_q == S_RD_R) || orphan_r_q;
      dbg_state_o   = state_q;
   end

   assign csr_o.awaddr   = awaddr_q;
   assign csr_o.awprot   = 3'b000;
   assign csr_o.wdata    = wdata_q;
   assign csr_o.wstrb    = wstrb_q;
   assign csr_o.araddr   = araddr_q;
   assign csr_o.arprot   = 3'b000;
   assign resp_rdata_o   = rdata_q;
   assign resp_code_o    = code_q;
   assign resp_timeout_o = timeout_q;

   // Command latch and per-phase completion of the write address/data channels
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         awaddr_q  <= '0;
         araddr_q  <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
      end else if (cmd_hs) begin
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
         if (cmd_wr_i) begin
            awaddr_q <= cmd_addr_i;
            wdata_q  <= cmd_wdata_i;
            wstrb_q  <= cmd_wstrb_i;
         end else begin
            araddr_q <= cmd_addr_i;
         end
      end else if (state_q == S_WR) begin
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
      end
   end

   // Response wait counter: cleared on entry to WR_B/RD_R, saturating
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         cnt_q <= '0;
      end else if ((state_d != state_q) && ((state_d == S_WR_B) || (state_d == S_RD_R))) begin
         cnt_q <= '0;
      end else if (((state_q == S_WR_B) || (state_q == S_RD_R)) && (cnt_q != CNT_MAX)) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   // Response capture and orphan tracking
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         rdata_q    <= '0;
         code_q     <= '0;
         timeout_q  <= 1'b0;
         orphan_b_q <= 1'b0;
         orphan_r_q <= 1'b0;
      end else begin
         if (state_q == S_WR_B) begin
            if (b_hs) begin
               rdata_q   <= '0;
               code_q    <= csr_o.bresp;
               timeout_q <= 1'b0;
            end else if (timeout_hit) begin
               rdata_q    <= '0;
               code_q     <= '0;
               timeout_q  <= 1'b1;
               orphan_b_q <= 1'b1;
            end
         end
         if (state_q == S_RD_R) begin
            if (r_hs) begin
               rdata_q   <= csr_o.rdata;
               code_q    <= csr_o.rresp;
               timeout_q <= 1'b0;
            end else if (timeout_hit) begin
               rdata_q    <= '0;
               code_q     <= '0;
               timeout_q  <= 1'b1;
               orphan_r_q <= 1'b1;
            end
         end
         // A late response after a timeout is accepted and thrown away.
         if (orphan_b_q && b_hs) orphan_b_q <= 1'b0;
         if (orphan_r_q && r_hs) orphan_r_q <= 1'b0;
      end
   end

endmodule

// File: tb/tb_axi4_lite_csr_master.sv
// Directed bench for axi4_lite_csr_master: write, skewed write, read, back-pressure,
// timeout with orphan drain, handshake-at-expiry and mid-transaction reset.
module tb_axi4_lite_csr_master;

   logic        clk;
   logic        rst_n;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_wr;
   logic [31:0] cmd_addr;
   logic [31:0] cmd_wdata;
   logic [3:0]  cmd_wstrb;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic [1:0]  resp_code;
   logic        resp_timeout;
   logic [2:0]  dbg_state;

   int vectors     = 0;
   int miscompares = 0;
   int aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;

   axi4_lite_if #(.ADDR_W(32)) csr ();

   axi4_lite_csr_master #(.ADDR_W(32), .TIMEOUT_CYCLES(8)) dut (
      .clk_i          (clk),
      .rst_n_i        (rst_n),
      .cmd_valid_i    (cmd_valid),
      .cmd_ready_o    (cmd_ready),
      .cmd_wr_i       (cmd_wr),
      .cmd_addr_i     (cmd_addr),
      .cmd_wdata_i    (cmd_wdata),
      .cmd_wstrb_i    (cmd_wstrb),
      .resp_valid_o   (resp_valid),
      .resp_ready_i   (resp_ready),
      .resp_rdata_o   (resp_rdata),
      .resp_code_o    (resp_code),
      .resp_timeout_o (resp_timeout),
      .csr_o          (csr),
      .dbg_state_o    (dbg_state)
   );

   // Clock/reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: observed no finish, required finish before 100000");
      $fatal(1, "watchdog expired");
   end

   // Bus beat counters
   always @(posedge clk) begin
      if (rst_n) begin
         if (csr.awvalid && csr.awready) aw_cnt <= aw_cnt + 1;
         if (csr.wvalid && csr.wready)   w_cnt  <= w_cnt + 1;
         if (csr.bvalid && csr.bready)   b_cnt  <= b_cnt + 1;
         if (csr.arvalid && csr.arready) ar_cnt <= ar_cnt + 1;
         if (csr.rvalid && csr.rready)   r_cnt  <= r_cnt + 1;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic send_cmd(input logic wr, input logic [31:0] addr,
                           input logic [31:0] data, input logic [3:0] strb);
      cmd_valid = 1'b1;
      cmd_wr    = wr;
      cmd_addr  = addr;
      cmd_wdata = data;
      cmd_wstrb = strb;
      tick();
      cmd_valid = 1'b0;
   endtask

   initial begin
      logic ok;
      int   i;
      rst_n = 1'b0; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0;
      cmd_wdata = '0; cmd_wstrb = '0; resp_ready = 1'b0;
      csr.awready = 1'b0; csr.wready = 1'b0; csr.bvalid = 1'b0; csr.bresp = '0;
      csr.arready = 1'b0; csr.rvalid = 1'b0; csr.rdata = '0; csr.rresp = '0;
      repeat (2) tick();

      // Reset values
      check("rst_handshakes", 64'({csr.awvalid, csr.wvalid, csr.bready, csr.arvalid,
                                   csr.rready, resp_valid, cmd_ready}), 64'd0);
      check("rst_resp", 64'({resp_rdata, resp_code, resp_timeout}), 64'd0);
      check("rst_addr_data", 64'({csr.awaddr, csr.wstrb}), 64'd0);
      check("rst_state", 64'(dbg_state), 64'd0);
      rst_n = 1'b1;
      #1;
      check("rel_cmd_ready", 64'(cmd_ready), 64'd1);

      // Plain write, zero-latency AW/W, B two cycles later
      csr.awready = 1'b1; csr.wready = 1'b1;
      send_cmd(1'b1, 32'h0, 32'h1, 4'hF);
      check("wr_valids", 64'({csr.awvalid, csr.wvalid, cmd_ready}), 64'b110);
      check("wr_payload", 64'({csr.awaddr, csr.wstrb}), {28'd0, 32'h0, 4'hF});
      check("wr_wdata", 64'(csr.wdata), 64'h1);
      tick();
      check("wr_b_wait", 64'({csr.awvalid, csr.wvalid, csr.bready}), 64'b001);
      check("wr_beats", 64'({aw_cnt[7:0], w_cnt[7:0]}), 64'h0101);
      tick();
      csr.bvalid = 1'b1; csr.bresp = 2'b00;
      tick();
      csr.bvalid = 1'b0;
      check("wr_resp", 64'({resp_valid, resp_timeout, resp_code, resp_rdata}), {29'd0, 1'b1, 1'b0, 2'b00, 32'h0});
      resp_ready = 1'b1;
      tick();
      resp_ready = 1'b0;
      check("wr_next_ready", 64'({cmd_ready, resp_valid, b_cnt[7:0]}), {54'd0, 2'b10, 8'd1});

      // Skewed write: W accepted several cycles after AW
      csr.awready = 1'b1; csr.wready = 1'b0;
      send_cmd(1'b1, 32'h10, 32'hA5A5_1234, 4'h3);
      check("skew_valids", 64'({csr.awvalid, csr.wvalid}), 64'b11);
      tick();
      check("skew_aw_dropped", 64'({csr.awvalid, csr.wvalid, csr.bready}), 64'b010);
      ok = 1'b1;
      repeat (4) begin
         tick();
         ok &= csr.wvalid && !csr.awvalid && !csr.bready && (csr.wdata == 32'hA5A5_1234)
               && (csr.wstrb == 4'h3);
      end
      check("skew_w_hold", 64'(ok), 64'd1);
      csr.wready = 1'b1;
      tick();
      csr.wready = 1'b0;
      check("skew_b_wait", 64'({csr.awvalid, csr.wvalid, csr.bready}), 64'b001);
      check("skew_beats", 64'({aw_cnt[7:0], w_cnt[7:0], csr.awaddr}), {16'd0, 8'd2, 8'd2, 32'h10});
      csr.bvalid = 1'b1; csr.bresp = 2'b01;
      tick();
      tick();
      csr.bvalid = 1'b0;
      check("skew_resp", 64'({resp_valid, resp_code, resp_timeout}), 64'b1010);
      check("skew_one_b", 64'(b_cnt), 64'd2);
      resp_ready = 1'b1;
      tick();
      resp_ready = 1'b0;
      check("skew_next_ready", 64'(cmd_ready), 64'd1);

      // Read with SLVERR, then consumer back-pressure for 10 cycles
      csr.arready = 1'b1;
      send_cmd(1'b0, 32'h0, 32'h0, 4'h0);
      check("rd_ar", 64'({csr.arvalid, csr.rready, cmd_ready}), 64'b100);
      check("rd_araddr", 64'(csr.araddr), 64'h0);
      tick();
      check("rd_r_wait", 64'({csr.arvalid, csr.rready, ar_cnt[7:0]}), {54'd0, 2'b01, 8'd1});
      csr.rvalid = 1'b1; csr.rdata = 32'h1; csr.rresp = 2'b10;
      tick();
      csr.rvalid = 1'b0; csr.rdata = 32'hFFFF_FFFF;
      check("rd_resp", 64'({resp_valid, resp_timeout, resp_code, resp_rdata}), {29'd0, 1'b1, 1'b0, 2'b10, 32'h1});
      cmd_valid = 1'b1; cmd_wr = 1'b1;
      ok = 1'b1;
      repeat (10) begin
         tick();
         ok &= resp_valid && (resp_rdata == 32'h1) && (resp_code == 2'b10) && !resp_timeout
               && !csr.awvalid && !csr.wvalid && !csr.arvalid && !cmd_ready;
      end
      cmd_valid = 1'b0;
      check("hold_stable", 64'(ok), 64'd1);
      check("hold_no_bus", 64'({aw_cnt[7:0], ar_cnt[7:0], r_cnt[7:0]}), 64'h020101);
      resp_ready = 1'b1;
      tick();
      resp_ready = 1'b0;
      check("rd_next_ready", 64'(cmd_ready), 64'd1);

      // Timeout: no B, then a late B drained
      csr.awready = 1'b1; csr.wready = 1'b1;
      send_cmd(1'b1, 32'h8, 32'hDEAD_BEEF, 4'hF);
      tick();
      check("to_entry", 64'({csr.bready, resp_valid}), 64'b10);
      i = 0;
      while (!resp_valid && i < 20) begin
         tick();
         i++;
      end
      check("to_latency", 64'(i), 64'd9);
      check("to_resp", 64'({resp_timeout, resp_code, resp_rdata}), {31'd0, 1'b1, 2'b00, 32'h0});
      check("to_busy", 64'({cmd_ready, csr.bready}), 64'b01);
      resp_ready = 1'b1;
      tick();
      resp_ready = 1'b0;
      check("to_orphan_idle", 64'({resp_valid, cmd_ready, csr.bready}), 64'b001);
      repeat (3) tick();
      check("to_orphan_hold", 64'({cmd_ready, dbg_state}), 64'h0);
      csr.bvalid = 1'b1; csr.bresp = 2'b10;
      tick();
      csr.bvalid = 1'b0;
      check("to_drained", 64'({cmd_ready, csr.bready, resp_valid}), 64'b100);
      check("to_drain_beats", 64'(b_cnt), 64'd3);

      // B handshake in the expiry cycle wins over the timeout
      send_cmd(1'b1, 32'hC, 32'h55, 4'hF);
      tick();
      repeat (8) tick();
      check("exp_not_yet", 64'({resp_valid, csr.bready}), 64'b01);
      csr.bvalid = 1'b1; csr.bresp = 2'b11;
      tick();
      csr.bvalid = 1'b0;
      check("exp_resp", 64'({resp_valid, resp_timeout, resp_code}), 64'b1011);
      resp_ready = 1'b1;
      tick();
      resp_ready = 1'b0;
      check("exp_no_orphan", 64'({cmd_ready, csr.bready, b_cnt[7:0]}), {54'd0, 2'b10, 8'd4});

      // Asynchronous reset while arvalid is high
      csr.arready = 1'b0;
      send_cmd(1'b0, 32'h40, 32'h0, 4'h0);
      check("mr_ar", 64'({csr.arvalid, csr.araddr}), {31'd0, 1'b1, 32'h40});
      #2;
      rst_n = 1'b0;
      #1;
      check("mr_async", 64'({csr.arvalid, resp_valid, cmd_ready}), 64'b000);
      check("mr_regs", 64'({csr.araddr, dbg_state}), 64'h0);
      tick();
      rst_n = 1'b1;
      #1;
      check("mr_release", 64'({cmd_ready, csr.arvalid, resp_valid}), 64'b100);
      tick();
      check("mr_quiet", 64'({cmd_ready, csr.arvalid, resp_valid, dbg_state}), 64'b100000);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
